// File: rtl/aes128_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_key_sched_ctrl
//   AES-128 key schedule sequencer. A cipher key is accepted on start, then one
//   round key per cycle is produced with the RotWord/SubWord/Rcon word function.
//   All 11 round keys are kept in an internal register file and served through
//   a registered read port.
//
//   Optional build macro: AES_KS_ZEROIZE_EN adds the zeroize input. zeroize
//   wipes the stored keys and aborts any expansion. With the macro defined,
//   reset also wipes storage.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   expansion request, held until start_ack
//   key_in     in   cipher key, key_in[127:96] = w0 ... key_in[31:0] = w3
//   start_ack  out  same-cycle acceptance pulse (key_in sampled)
//   busy       out  expansion in progress (LOAD through the done cycle)
//   done       out  one-cycle pulse in the cycle round key 10 is written
//   rk_valid   out  bit r set = round key r stored and readable
//   rd_en      in   read request
//   rd_idx     in   round key index 0..10
//   rd_data    out  round key (0 on error), valid with rd_valid
//   rd_valid   out  read response strobe, one cycle after rd_en
//   rd_err     out  with rd_valid: bad index, key not stored, or being written
//   zeroize    in   storage wipe (only with AES_KS_ZEROIZE_EN)
// ---------------------------------------------------------------------------
module aes128_key_sched_ctrl #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             start_ack,
    output logic             busy,
    output logic             done,
    output logic [NR:0]      rk_valid,
    input  logic             rd_en,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err
`ifdef AES_KS_ZEROIZE_EN
    ,
    input  logic             zeroize
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND} state_t;

    state_t           state;
    logic [3:0]       round;
    logic [KEY_W-1:0] cur_key;
    logic [KEY_W-1:0] rk [0:NR];
    logic [KEY_W-1:0] next_key;
    logic [31:0]      w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [15:0]      vld_ext;
    logic             wr_hit;
    logic             rd_bad;
    logic             zz;

`ifdef AES_KS_ZEROIZE_EN
    assign zz = zeroize;
`else
    assign zz = 1'b0;
`endif

    // GF(2^8) multiply, AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed rather than tabled: inverse as a^254 (squares a^2..a^128
    // multiplied together; 0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] b;
        sq = a;
        b  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // RConLookup: iterate 1..10 -> round constant byte.
    function automatic logic [7:0] rcon(input logic [7:0] iter);
        logic [7:0] v;
        case (iter)
            8'd1:    v = 8'h01;
            8'd2:    v = 8'h02;
            8'd3:    v = 8'h04;
            8'd4:    v = 8'h08;
            8'd5:    v = 8'h10;
            8'd6:    v = 8'h20;
            8'd7:    v = 8'h40;
            8'd8:    v = 8'h80;
            8'd9:    v = 8'h1b;
            8'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Word function on the previous round key held in cur_key.
    assign w0 = cur_key[127:96];
    assign w1 = cur_key[95:64];
    assign w2 = cur_key[63:32];
    assign w3 = cur_key[31:0];
    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon({4'b0000, round}), 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // Acceptance is combinational so the key is sampled in the request cycle.
    assign start_ack = rst_n && !zz && start && (state == S_IDLE);

    // A read of the slot being written this cycle reports an error, no bypass.
    assign vld_ext = {{(15 - NR){1'b0}}, rk_valid};
    assign wr_hit  = ((state == S_LOAD) && (rd_idx == 4'd0)) ||
                     ((state == S_EXPAND) && (rd_idx == round));
    assign rd_bad  = (rd_idx > 4'(NR)) || !vld_ext[rd_idx] || wr_hit;

    // Control FSM; done is raised one cycle early so it lines up with round 10.
    always_ff @(posedge clk) begin
        if (!rst_n || zz) begin
            state    <= S_IDLE;
            round    <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rk_valid <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    rk_valid <= {{NR{1'b0}}, 1'b1};
                    round    <= 4'd1;
                    state    <= S_EXPAND;
                end
                S_EXPAND: begin
                    rk_valid[round] <= 1'b1;
                    if (round == 4'(NR - 1)) done <= 1'b1;
                    if (round == 4'(NR)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Key storage and working key.
    always_ff @(posedge clk) begin
`ifdef AES_KS_ZEROIZE_EN
        if (!rst_n || zz) begin
            cur_key <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else
`endif
        begin
            if (start_ack) cur_key <= key_in;
            else if (state == S_EXPAND) cur_key <= next_key;
            if (state == S_LOAD) rk[0] <= cur_key;
            if (state == S_EXPAND) rk[round] <= next_key;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else if (zz) begin
            rd_valid <= rd_en;
            rd_err   <= rd_en;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && rd_bad;
            if (rd_en) rd_data <= rd_bad ? '0 : rk[rd_idx];
        end
    end

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes128_key_sched_ctrl
//   Scoreboard bench. A driver issues one cycle of stimulus at a time, checks
//   control outputs against a cycle-level reference model and queues the
//   expected read response; a monitor pops and compares on rd_valid.
//   The reference model expands keys with the FIPS-197 word loop and a tabled
//   S-box. Define AES_KS_ZEROIZE_EN to exercise the zeroize input.
// ---------------------------------------------------------------------------
module tb_aes128_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         start_ack;
    logic         busy;
    logic         done;
    logic [10:0]  rk_valid;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_err;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize;
`endif

    aes128_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .start_ack (start_ack),
        .busy      (busy),
        .done      (done),
        .rk_valid  (rk_valid),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err)
`ifdef AES_KS_ZEROIZE_EN
        ,
        .zeroize   (zeroize)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         err;
        logic [127:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      checks   = 0;
    int      failures = 0;
    logic    mon_en   = 1'b0;

    // Reference model state: m_phase = -1 idle, 0 loading rk0, r = writing rk r.
    int           m_phase = -1;
    logic [10:0]  m_rkv   = '0;
    logic [127:0] m_new   [11];
    logic [127:0] m_store [11];
    int           cyc      = 0;
    int           ack_cyc  = 0;
    int           ack_seen = 0;
    int           done_lat = -1;

    logic [2047:0] sbox_flat = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [31:0] m_sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            int x;
            x = int'(w[8*b +: 8]);
            r[8*b +: 8] = sbox_flat[2047 - 8*x -: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] m_rcon(input int r);
        logic [7:0] v;
        v = 8'h01;
        for (int j = 1; j < r; j++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        return v;
    endfunction

    task automatic expand_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = m_sub_word({tmp[23:0], tmp[31:24]}) ^ {m_rcon(i / 4), 24'h0};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) m_new[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per read response.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: rd_valid=1 with no read issued (cycle %0d)", cyc);
                end else begin
                    rd_exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (rd_err !== e.err || rd_data !== e.data) begin
                        failures++;
                        $display("FAIL rd_resp: got err=%b data=%h expected err=%b data=%h (cycle %0d)",
                                 rd_err, rd_data, e.err, e.data, cyc);
                    end
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                checks++;
                failures++;
                $display("FAIL rd_missing: rd_valid=0 expected 1 (cycle %0d)", cyc);
            end
        end
    end

    // One clock of stimulus plus model update.
    task automatic do_cycle(input logic s, input logic [127:0] k, input logic re,
                            input logic [3:0] idx, input logic rn, input logic zz,
                            input logic kat, input logic [127:0] kat_val);
        logic    exp_ack;
        logic    bad;
        rd_exp_t e;
        @(negedge clk);
        #1;
        cyc++;
        chk("busy", busy, m_phase >= 0);
        chk("done", done, m_phase == 10);
        chk("rk_valid", rk_valid, m_rkv);
        if (done === 1'b1) done_lat = cyc - ack_cyc;
        start  = s;
        key_in = k;
        rd_en  = re;
        rd_idx = idx;
        rst_n  = rn;
`ifdef AES_KS_ZEROIZE_EN
        zeroize = zz;
`endif
        #1;
        exp_ack = rn && !zz && s && (m_phase < 0);
        chk("start_ack", start_ack, exp_ack);
        if (start_ack === 1'b1) begin
            ack_seen++;
            ack_cyc = cyc;
        end
        if (rn && re) begin
            bad = zz || (idx > 4'd10);
            if (!bad) bad = !m_rkv[idx] || (m_phase >= 0 && int'(idx) == m_phase);
            e.err  = bad;
            e.data = bad ? 128'h0 : (kat ? kat_val : m_store[idx]);
            exp_q.push_back(e);
        end
        if (!rn || zz) begin
            m_phase = -1;
            m_rkv   = '0;
        end else if (m_phase < 0) begin
            if (s) begin
                expand_model(k);
                m_phase = 0;
            end
        end else begin
            m_store[m_phase] = m_new[m_phase];
            if (m_phase == 0) m_rkv = 11'b1;
            else m_rkv[m_phase] = 1'b1;
            m_phase = (m_phase == 10) ? -1 : m_phase + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 128'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 128'h0);
    endtask

    task automatic go(input logic [127:0] k);
        do_cycle(1'b1, k, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 128'h0);
    endtask

    task automatic rd(input logic [3:0] idx);
        do_cycle(1'b0, 128'h0, 1'b1, idx, 1'b1, 1'b0, 1'b0, 128'h0);
    endtask

    task automatic rd_kat(input logic [3:0] idx, input logic [127:0] v);
        do_cycle(1'b0, 128'h0, 1'b1, idx, 1'b1, 1'b0, 1'b1, v);
    endtask

    task automatic read_all();
        for (int i = 0; i < 11; i++) rd(4'(i));
    endtask

    logic [127:0] rkey;
    int           a0;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rd_en  = 1'b0;
        rd_idx = '0;
`ifdef AES_KS_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rk_valid", rk_valid, 11'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("rst_rd_data", rd_data, 128'h0);
        chk("rst_start_ack", start_ack, 1'b0);
        mon_en = 1'b1;

        // FIPS-197 A.1 vector and latency
        go(128'h2b7e151628aed2a6abf7158809cf4f3c);
        idle(11);
        chk("latency", done_lat, 11);
        rd_kat(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_kat(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_kat(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // All-zero key
        go(128'h0);
        idle(11);
        rd_kat(4'd1, 128'h62636363626363636263636362636363);
        rd_kat(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Reads during expansion, at done, and out of range
        rkey = {$urandom, $urandom, $urandom, $urandom};
        go(rkey);
        idle(2);
        rd(4'd5);
        idle(7);
        rd(4'd10);
        rd(4'd10);
        rd(4'd5);
        rd(4'd11);
        rd(4'd15);

        // start held through busy; key changes while busy
        a0 = ack_seen;
        rkey = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 23; i++)
            do_cycle(1'b1, (i < 5) ? ~rkey : rkey, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 128'h0);
        idle(1);
        chk("held_acks", ack_seen - a0, 2);
        read_all();

        // Reset in round 4, then a clean expansion
        go({$urandom, $urandom, $urandom, $urandom});
        idle(4);
        do_cycle(1'b0, 128'h0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 128'h0);
        rd(4'd0);
        go({$urandom, $urandom, $urandom, $urandom});
        idle(11);
        read_all();

`ifdef AES_KS_ZEROIZE_EN
        // Zeroize in round 6
        go({$urandom, $urandom, $urandom, $urandom});
        idle(6);
        do_cycle(1'b1, 128'h0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 128'h0);
        rd(4'd0);
        rd(4'd3);
        go({$urandom, $urandom, $urandom, $urandom});
        idle(11);
        read_all();
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic zr;
            zr = 1'b0;
`ifdef AES_KS_ZEROIZE_EN
            zr = ($urandom_range(0, 79) == 0);
`endif
            do_cycle($urandom_range(0, 3) == 0, {$urandom, $urandom, $urandom, $urandom},
                     $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 79) != 0, zr, 1'b0, 128'h0);
        end

        idle(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
